// File: rtl/alu_share_arb_if.sv
// Handshake bundle between the two ALU requesters, the shared-ALU arbiter and the writeback consumer.
// The arbiter uses the slave view; the issue/writeback side uses the master view.
interface alu_share_arb_if #(
    parameter int CNT_W = 16
);
    logic             req0_valid;
    logic             req0_ready;
    logic [3:0]       req0_ctrl;
    logic [7:0]       req0_a;
    logic [7:0]       req0_b;
    logic             req1_valid;
    logic             req1_ready;
    logic [3:0]       req1_ctrl;
    logic [7:0]       req1_a;
    logic [7:0]       req1_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [7:0]       rsp_result;
    logic             rsp_zero;
    logic             rsp_carry;
    logic             rsp_ovf;
    logic [CNT_W-1:0] op_count;

    modport slave (
        input  req0_valid, req0_ctrl, req0_a, req0_b,
        input  req1_valid, req1_ctrl, req1_a, req1_b,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_carry, rsp_ovf, op_count
    );

    modport master (
        output req0_valid, req0_ctrl, req0_a, req0_b,
        output req1_valid, req1_ctrl, req1_a, req1_b,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_carry, rsp_ovf, op_count
    );
endinterface

// File: rtl/alu_share_arb.sv
// Two-requester arbiter for one shared 8-bit ALU, with a one-entry registered response buffer.
// state    | meaning
// EMPTY    | no response buffered; any valid request is accepted
// FULL     | response held on rsp_*; new accept only together with a drain
module alu_share_arb #(
    parameter int RR_EN = 1,
    parameter int CNT_W = 16
) (
    input logic          clk,
    input logic          reset,
    alu_share_arb_if.slave bus
);
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic             last_q;
    logic             id_q;
    logic [7:0]       res_q;
    logic             zero_q, carry_q, ovf_q;
    logic [CNT_W-1:0] cnt_q;

    logic       grant, can_accept, accept, drain;
    logic [3:0] op_ctrl;
    logic [7:0] op_a, op_b, alu_res;
    logic       alu_carry, alu_ovf;
    logic [8:0] sum9, diff9;

    always_comb begin
        // Contended grant goes to whoever did not win last; last_q resets to 1 so requester 0 wins first.
        if (bus.req0_valid && bus.req1_valid)
            grant = (RR_EN != 0) ? ~last_q : 1'b0;
        else
            grant = bus.req1_valid;
        can_accept = (state_q == ST_EMPTY) || bus.rsp_ready;
        accept     = can_accept && (bus.req0_valid || bus.req1_valid);
        drain      = (state_q == ST_FULL) && bus.rsp_ready;

        op_ctrl = grant ? bus.req1_ctrl : bus.req0_ctrl;
        op_a    = grant ? bus.req1_a    : bus.req0_a;
        op_b    = grant ? bus.req1_b    : bus.req0_b;
        sum9    = {1'b0, op_a} + {1'b0, op_b};
        diff9   = {1'b0, op_a} - {1'b0, op_b};

        alu_res   = 8'h00;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (op_ctrl)
            4'd0:  alu_res = op_a & op_b;
            4'd1:  alu_res = op_a | op_b;
            4'd2: begin
                alu_res   = sum9[7:0];
                alu_carry = sum9[8];
                alu_ovf   = (op_a[7] == op_b[7]) && (sum9[7] != op_a[7]);
            end
            4'd6: begin
                alu_res   = diff9[7:0];
                alu_carry = ~diff9[8];
                alu_ovf   = (op_a[7] != op_b[7]) && (diff9[7] != op_a[7]);
            end
            4'd7:  alu_res = {7'b0, (op_a < op_b)};
            4'd12: alu_res = ~(op_a | op_b);
            default: alu_res = 8'h00;
        endcase

        if (accept)
            state_d = ST_FULL;
        else if (drain)
            state_d = ST_EMPTY;
        else
            state_d = state_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            res_q   <= 8'h00;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                last_q  <= grant;
                id_q    <= grant;
                res_q   <= alu_res;
                zero_q  <= (alu_res == 8'h00);
                carry_q <= alu_carry;
                ovf_q   <= alu_ovf;
                cnt_q   <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.req0_ready = can_accept && bus.req0_valid && !grant;
    assign bus.req1_ready = can_accept && bus.req1_valid && grant;
    assign bus.rsp_valid  = (state_q == ST_FULL);
    assign bus.rsp_id     = id_q;
    assign bus.rsp_result = res_q;
    assign bus.rsp_zero   = zero_q;
    assign bus.rsp_carry  = carry_q;
    assign bus.rsp_ovf    = ovf_q;
    assign bus.op_count   = cnt_q;
endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: a round-robin and a fixed-priority instance share one stimulus stream
// and are compared every cycle against a transaction-level model.
module tb_alu_share_arb;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       d_v0, d_v1, d_rr;
    logic [3:0] d_c0, d_c1;
    logic [7:0] d_a0, d_b0, d_a1, d_b1;

    alu_share_arb_if #(.CNT_W(16)) bus0 ();
    alu_share_arb_if #(.CNT_W(16)) bus1 ();

    assign bus0.req0_valid = d_v0;  assign bus1.req0_valid = d_v0;
    assign bus0.req0_ctrl  = d_c0;  assign bus1.req0_ctrl  = d_c0;
    assign bus0.req0_a     = d_a0;  assign bus1.req0_a     = d_a0;
    assign bus0.req0_b     = d_b0;  assign bus1.req0_b     = d_b0;
    assign bus0.req1_valid = d_v1;  assign bus1.req1_valid = d_v1;
    assign bus0.req1_ctrl  = d_c1;  assign bus1.req1_ctrl  = d_c1;
    assign bus0.req1_a     = d_a1;  assign bus1.req1_a     = d_a1;
    assign bus0.req1_b     = d_b1;  assign bus1.req1_b     = d_b1;
    assign bus0.rsp_ready  = d_rr;  assign bus1.rsp_ready  = d_rr;

    alu_share_arb #(.RR_EN(1), .CNT_W(16)) dut_rr  (.clk(clk), .reset(reset), .bus(bus0));
    alu_share_arb #(.RR_EN(0), .CNT_W(16)) dut_fix (.clk(clk), .reset(reset), .bus(bus1));

    int checks = 0;
    int errors = 0;

    // model state, index 0 = round-robin instance, 1 = fixed priority
    int m_full[2], m_last[2], m_cnt[2], m_id[2], m_res[2], m_z[2], m_c[2], m_o[2];
    int e_r0[2], e_r1[2], e_g[2];

    typedef struct {
        int ctrl; int a; int b;
        int res;  int z; int c; int o;
    } vec_t;
    vec_t tbl[10];

    function automatic void chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void model_alu(input int c, input int a, input int b,
                                      output int r, output int z, output int cy, output int ov);
        int sa, sb;
        sa = (a > 127) ? a - 256 : a;
        sb = (b > 127) ? b - 256 : b;
        r = 0; cy = 0; ov = 0;
        case (c)
            0:  r = a & b;
            1:  r = a | b;
            2:  begin r = (a + b) % 256; cy = (a + b > 255); ov = (sa + sb > 127) || (sa + sb < -128); end
            6:  begin r = (a - b + 256) % 256; cy = (a >= b); ov = (sa - sb > 127) || (sa - sb < -128); end
            7:  r = (a < b) ? 1 : 0;
            12: r = 255 - (a | b);
            default: r = 0;
        endcase
        z = (r == 0);
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_full[k] = 0; m_last[k] = 1; m_cnt[k] = 0; m_id[k] = 0;
            m_res[k] = 0; m_z[k] = 0; m_c[k] = 0; m_o[k] = 0;
        end
    endfunction

    function automatic void check_dut(int k, logic r0, logic r1, logic rv, logic id,
                                      logic [7:0] res, logic z, logic c, logic o, logic [15:0] cnt);
        string p;
        p = (k == 0) ? "rr" : "fix";
        chk({p, "_req0_ready"}, int'(r0), e_r0[k]);
        chk({p, "_req1_ready"}, int'(r1), e_r1[k]);
        chk({p, "_rsp_valid"}, int'(rv), m_full[k]);
        chk({p, "_op_count"}, int'(cnt), m_cnt[k]);
        if (m_full[k] != 0) begin
            chk({p, "_rsp_id"}, int'(id), m_id[k]);
            chk({p, "_rsp_result"}, int'(res), m_res[k]);
            chk({p, "_rsp_zero"}, int'(z), m_z[k]);
            chk({p, "_rsp_carry"}, int'(c), m_c[k]);
            chk({p, "_rsp_ovf"}, int'(o), m_o[k]);
        end
    endfunction

    task automatic drive(input logic v0, input int c0, input int a0, input int b0,
                         input logic v1, input int c1, input int a1, input int b1, input logic rr);
        d_v0 = v0; d_c0 = 4'(c0); d_a0 = 8'(a0); d_b0 = 8'(b0);
        d_v1 = v1; d_c1 = 4'(c1); d_a1 = 8'(a1); d_b1 = 8'(b1);
        d_rr = rr;
    endtask

    task automatic cycle();
        int can, r, z, cy, ov;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            can = (m_full[k] == 0) || d_rr;
            if (d_v0 && d_v1)      e_g[k] = (k == 0) ? 1 - m_last[k] : 0;
            else if (d_v1)         e_g[k] = 1;
            else if (d_v0)         e_g[k] = 0;
            else                   e_g[k] = -1;
            e_r0[k] = (can != 0) && (e_g[k] == 0);
            e_r1[k] = (can != 0) && (e_g[k] == 1);
        end
        check_dut(0, bus0.req0_ready, bus0.req1_ready, bus0.rsp_valid, bus0.rsp_id, bus0.rsp_result,
                  bus0.rsp_zero, bus0.rsp_carry, bus0.rsp_ovf, bus0.op_count);
        check_dut(1, bus1.req0_ready, bus1.req1_ready, bus1.rsp_valid, bus1.rsp_id, bus1.rsp_result,
                  bus1.rsp_zero, bus1.rsp_carry, bus1.rsp_ovf, bus1.op_count);
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (e_r0[k] != 0 || e_r1[k] != 0) begin
                if (e_g[k] == 1) model_alu(int'(d_c1), int'(d_a1), int'(d_b1), r, z, cy, ov);
                else             model_alu(int'(d_c0), int'(d_a0), int'(d_b0), r, z, cy, ov);
                m_full[k] = 1; m_id[k] = e_g[k]; m_last[k] = e_g[k];
                m_res[k] = r; m_z[k] = z; m_c[k] = cy; m_o[k] = ov;
                m_cnt[k] = (m_cnt[k] + 1) % 65536;
            end else if (m_full[k] != 0 && d_rr) begin
                m_full[k] = 0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        model_reset();
        chk("rst_rsp_valid", int'(bus0.rsp_valid), 0);
        chk("rst_rsp_result", int'(bus0.rsp_result), 0);
        chk("rst_rsp_flags", int'({bus0.rsp_zero, bus0.rsp_carry, bus0.rsp_ovf, bus0.rsp_id}), 0);
        chk("rst_op_count", int'(bus0.op_count), 0);
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int rr_exp[4];
        logic [7:0] held_res;
        logic held_id;

        tbl[0] = '{2,  8'hFF, 8'h01, 8'h00, 1, 1, 0};
        tbl[1] = '{2,  8'h7F, 8'h01, 8'h80, 0, 0, 1};
        tbl[2] = '{6,  8'h03, 8'h05, 8'hFE, 0, 0, 0};
        tbl[3] = '{7,  8'h03, 8'h05, 8'h01, 0, 0, 0};
        tbl[4] = '{5,  8'h12, 8'h34, 8'h00, 1, 0, 0};
        tbl[5] = '{0,  8'hF0, 8'h3C, 8'h30, 0, 0, 0};
        tbl[6] = '{1,  8'hF0, 8'h0C, 8'hFC, 0, 0, 0};
        tbl[7] = '{12, 8'hF0, 8'h0C, 8'h03, 0, 0, 0};
        tbl[8] = '{6,  8'h80, 8'h01, 8'h7F, 0, 1, 1};
        tbl[9] = '{6,  8'h05, 8'h05, 8'h00, 1, 1, 0};
        rr_exp = '{0, 1, 0, 1};

        // idle after reset: nothing ready, nothing buffered
        do_reset();
        for (int i = 0; i < 3; i++) cycle();
        chk("idle_ready0", int'(bus0.req0_ready), 0);
        chk("idle_ready1", int'(bus0.req1_ready), 0);

        // ALU vectors, alternating requester
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) drive(1, tbl[i].ctrl, tbl[i].a, tbl[i].b, 0, 0, 0, 0, 1);
            else            drive(0, 0, 0, 0, 1, tbl[i].ctrl, tbl[i].a, tbl[i].b, 1);
            cycle();
            drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
            chk($sformatf("vec%0d_valid", i), int'(bus0.rsp_valid), 1);
            chk($sformatf("vec%0d_id", i), int'(bus0.rsp_id), i % 2);
            chk($sformatf("vec%0d_result", i), int'(bus0.rsp_result), tbl[i].res);
            chk($sformatf("vec%0d_zero", i), int'(bus0.rsp_zero), tbl[i].z);
            chk($sformatf("vec%0d_carry", i), int'(bus0.rsp_carry), tbl[i].c);
            chk($sformatf("vec%0d_ovf", i), int'(bus0.rsp_ovf), tbl[i].o);
        end
        cycle();

        // contention: round-robin alternates, fixed priority always picks 0
        do_reset();
        drive(1, 2, 8'h10, 8'h01, 1, 0, 8'hAA, 8'h0F, 1);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk($sformatf("rr_id%0d", i), int'(bus0.rsp_id), rr_exp[i]);
            chk($sformatf("fix_id%0d", i), int'(bus1.rsp_id), 0);
        end
        chk("rr_op_count4", int'(bus0.op_count), 4);
        chk("fix_op_count4", int'(bus1.op_count), 4);

        // backpressure: buffer full, consumer stalls for 3 cycles
        drive(1, 1, 8'h01, 8'h02, 1, 6, 8'h09, 8'h04, 0);
        held_res = bus0.rsp_result;
        held_id  = bus0.rsp_id;
        #1;
        chk("stall_ready0", int'(bus0.req0_ready), 0);
        chk("stall_ready1", int'(bus0.req1_ready), 0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk($sformatf("stall_valid%0d", i), int'(bus0.rsp_valid), 1);
            chk($sformatf("stall_result%0d", i), int'(bus0.rsp_result), int'(held_res));
            chk($sformatf("stall_id%0d", i), int'(bus0.rsp_id), int'(held_id));
        end
        d_rr = 1'b1;
        cycle();
        chk("drain_accept_valid", int'(bus0.rsp_valid), 1);
        chk("drain_accept_count", int'(bus0.op_count), 5);

        // async reset with a buffered response
        drive(1, 2, 8'h01, 8'h01, 0, 0, 0, 0, 0);
        cycle();
        chk("pre_reset_valid", int'(bus0.rsp_valid), 1);
        reset = 1'b1;
        #1;
        chk("async_reset_valid_rr", int'(bus0.rsp_valid), 0);
        chk("async_reset_valid_fix", int'(bus1.rsp_valid), 0);
        do_reset();
        drive(1, 0, 8'hFF, 8'h0F, 1, 1, 8'h00, 8'h00, 1);
        cycle();
        chk("post_reset_first_id", int'(bus0.rsp_id), 0);
        cycle();

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 255),
                  1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 255),
                  1'($urandom_range(0, 3) != 0));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
